// File: rtl/popcount_engine_pkg.sv
// Shared typedefs for the popcount engine: control FSM state encoding.
package popcount_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/popcount_datapath.sv
// Shift register and running count for the popcount engine; the FSM in the
// top level drives load/step/clear and reads back the zero flags.
module popcount_datapath
  import popcount_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             load_zero_o,
  output logic             rem_zero_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] loadVal;

  // Zero-count mode inverts at load so leading zeros are counted as well.
  assign loadVal     = data_i ^ {WIDTH{mode_i}};
  assign load_zero_o = (loadVal == '0);
  assign rem_zero_o  = ((sr_q >> 1) == '0);
  assign cnt_o       = cnt_q;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (load_i) begin
      sr_d  = loadVal;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(sr_q[0]);
      sr_d  = sr_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/popcount_engine.sv
// Serial ones/zeros counter with valid/ready handshakes on both sides.
// Top level holds only the control FSM and handshake decoding.
module popcount_engine
  import popcount_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             load;
  logic             step;
  logic             loadZero;
  logic             remZero;
  logic [CNT_W-1:0] cnt;

  // A word offered alongside clear is refused; clear wins every handshake.
  assign load = (state_q == IDLE) && in_valid && !clear;
  assign step = (state_q == SCAN) && !clear;

  popcount_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .load_i     (load),
    .step_i     (step),
    .data_i     (in_data),
    .mode_i     (in_mode),
    .cnt_o      (cnt),
    .load_zero_o(loadZero),
    .rem_zero_o (remZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = loadZero ? DONE : SCAN;
        SCAN:    if (remZero) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SCAN);
    out_count = (state_q == DONE) ? cnt : '0;
  end

endmodule

// File: tb/tb_popcount_engine.sv
// Scoreboard bench for popcount_engine: directed corner words, then random
// words with random result backpressure.
module tb_popcount_engine;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  typedef struct {
    int count;
    int k;
    int acceptCycle;
  } exp_t;

  exp_t sbQ[$];
  int   assertions = 0;
  int   failures = 0;
  int   cycle = 0;
  int   readyMode = 0;
  bit   seenValid = 0;
  bit   clearPending = 0;
  bit   expectReady = 0;

  popcount_engine #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Result-side consumer: always ready, random, or stalled.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: count differing bits over the full word, k = top set bit + 1.
  function automatic void refModel(input logic [WIDTH-1:0] data, input logic mode,
                                   output int cnt, output int k);
    cnt = 0;
    k   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i] != mode) begin
        cnt++;
        k = i + 1;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic mode);
    exp_t e;
    bit   accepted = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready && !clear) begin
        refModel(data, mode, e.count, e.k);
        e.acceptCycle = cycle + 1;
        sbQ.push_back(e);
        accepted = 1;
        break;
      end
    end
    assertions++;
    if (!accepted) begin
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit drained = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sbQ.size() == 0) begin
        drained = 1;
        break;
      end
    end
    assertions++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sbQ.size());
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbQ.delete();
      seenValid    = 0;
      clearPending = 0;
      expectReady  = 0;
    end else begin
      if (clearPending) begin
        checkOutput("clear_in_ready", int'(in_ready), 1);
        checkOutput("clear_out_valid", int'(out_valid), 0);
        checkOutput("clear_busy", int'(busy), 0);
        clearPending = 0;
      end
      if (expectReady) begin
        checkOutput("ready_after_handshake", int'(in_ready), 1);
        expectReady = 0;
      end
      if (clear) begin
        sbQ.delete();
        seenValid    = 0;
        clearPending = 1;
      end else if (out_valid) begin
        if (sbQ.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL spurious_result: out_valid=1 count=%0d, expected no result", out_count);
        end else begin
          checkOutput("out_count", int'(out_count), sbQ[0].count);
          checkOutput("in_ready_in_done", int'(in_ready), 0);
          if (!seenValid) begin
            checkOutput("latency_cycle", cycle, sbQ[0].acceptCycle + sbQ[0].k);
            seenValid = 1;
          end
          if (out_ready) begin
            void'(sbQ.pop_front());
            seenValid   = 0;
            expectReady = 1;
          end
        end
      end else if (sbQ.size() > 0 && cycle >= sbQ[0].acceptCycle) begin
        checkOutput("busy_scan", int'(busy), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rdata;
    logic             rmode;

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_count", int'(out_count), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a scan.
    applyStimulus(16'hAAAA, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    checkOutput("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midscan_reset_in_ready", int'(in_ready), 1);
    checkOutput("midscan_reset_out_valid", int'(out_valid), 0);
    checkOutput("midscan_reset_out_count", int'(out_count), 0);
    checkOutput("midscan_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    readyMode = 0;
    applyStimulus(16'h00F0, 1'b0); waitDrain();
    applyStimulus(16'h0000, 1'b0); waitDrain();
    applyStimulus(16'hFFFF, 1'b1); waitDrain();
    applyStimulus(16'h8001, 1'b1); waitDrain();
    applyStimulus(16'hFFFF, 1'b0); waitDrain();

    // Stalled consumer: result must hold while out_ready is low.
    readyMode = 2;
    applyStimulus(16'h0F0F, 1'b0);
    for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
    checkOutput("stall_out_valid", int'(out_valid), 1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_hold_count", int'(out_count), 8);
      checkOutput("stall_hold_valid", int'(out_valid), 1);
    end
    readyMode = 0;
    waitDrain();

    // Synchronous abort during a scan, then a normal word.
    applyStimulus(16'hAAAA, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(16'h0003, 1'b0); waitDrain();

    readyMode = 1;
    for (int n = 0; n < 40; n++) begin
      rdata = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
      rmode = 1'($urandom_range(0, 1));
      if (rmode) rdata = ~rdata;
      applyStimulus(rdata, rmode);
      waitDrain();
    end
    readyMode = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
